// File: rtl/apple_generator.sv
// Apple placement for the snake game: detects the head reaching the apple, then searches
// LFSR-derived candidate cells against the snake body until a free one (or the retry limit).
module apple_generator #(
  parameter logic [5:0]  INIT_X    = 6'd30,
  parameter logic [5:0]  INIT_Y    = 6'd10,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MAX_RETRY = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [5:0] head_x,
  input  logic [5:0] head_y,
  input  logic [3:0] cubenum,
  input  logic [5:0] node_cube_x,
  input  logic [5:0] node_cube_y,
  output logic [3:0] node,
  output logic [5:0] apple_x,
  output logic [5:0] apple_y,
  output logic       eat,
  output logic       busy
);

  localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  typedef enum logic [1:0] {StIdle, StGen, StScan, StPlace} state_e;

  state_e            state_q;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [5:0]        cand_x_q, cand_y_q;
  logic [5:0]        apple_x_q, apple_y_q;
  logic [3:0]        idx_q;
  logic [RetryW-1:0] retry_q;
  logic [5:0]        rx, ry, gen_x, gen_y;
  logic [3:0]        last_idx;
  logic              play, hit;

  // Fibonacci LFSR, taps 16,14,13,11; the zero guard only matters for a zero SEED
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (lfsr_d == 16'h0000) begin
      lfsr_d = 16'h0001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Fold the 6-bit LFSR fields onto the 38x28 playfield
  always_comb begin
    rx    = lfsr_q[5:0];
    ry    = lfsr_q[13:8];
    gen_x = ((rx >= 6'd38) ? (rx - 6'd38) : rx) + 6'd1;
    if (ry >= 6'd56) begin
      gen_y = ry - 6'd56 + 6'd1;
    end else if (ry >= 6'd28) begin
      gen_y = ry - 6'd28 + 6'd1;
    end else begin
      gen_y = ry + 6'd1;
    end
  end

  assign play     = (mode == 2'd1);
  assign last_idx = (cubenum >= 4'd13) ? 4'd15 : (cubenum + 4'd2);
  assign hit      = (node_cube_x == cand_x_q) && (node_cube_y == cand_y_q);

  assign eat     = play && (state_q == StIdle) && (head_x == apple_x_q) && (head_y == apple_y_q);
  assign busy    = (state_q != StIdle);
  assign node    = (state_q == StScan) ? idx_q : 4'd0;
  assign apple_x = apple_x_q;
  assign apple_y = apple_y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      apple_x_q <= INIT_X;
      apple_y_q <= INIT_Y;
      cand_x_q  <= 6'd0;
      cand_y_q  <= 6'd0;
      idx_q     <= 4'd0;
      retry_q   <= '0;
    end else if (!play) begin
      state_q   <= StIdle;
      apple_x_q <= INIT_X;
      apple_y_q <= INIT_Y;
      idx_q     <= 4'd0;
      retry_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (eat) begin
            state_q <= StGen;
          end
        end
        StGen: begin
          cand_x_q <= gen_x;
          cand_y_q <= gen_y;
          idx_q    <= 4'd0;
          state_q  <= StScan;
        end
        StScan: begin
          if (hit) begin
            if (retry_q == RetryMax) begin
              state_q <= StPlace;
            end else begin
              retry_q <= retry_q + 1'b1;
              state_q <= StGen;
            end
          end else if (idx_q >= last_idx) begin
            // >= keeps the scan bounded if cubenum shrinks mid-scan
            state_q <= StPlace;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        StPlace: begin
          apple_x_q <= cand_x_q;
          apple_y_q <= cand_y_q;
          retry_q   <= '0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apple_generator.sv
// Directed bench for apple_generator: an independent LFSR model predicts every candidate,
// and a small body model injects collisions against that candidate.
module tb_apple_generator;

  localparam int MaxRetry = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [5:0] head_x, head_y;
  logic [3:0] cubenum;
  logic [5:0] node_cube_x, node_cube_y;
  logic [3:0] node;
  logic [5:0] apple_x, apple_y;
  logic       eat, busy;

  int total = 0;
  int errs  = 0;

  logic [15:0] m_lfsr;
  logic [5:0]  cand_x = 6'd0, cand_y = 6'd0;
  logic        hit_en = 1'b0;
  logic [3:0]  hit_node = 4'd0;

  apple_generator #(
    .INIT_X   (6'd30),
    .INIT_Y   (6'd10),
    .SEED     (16'hACE1),
    .MAX_RETRY(MaxRetry)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .head_x     (head_x),
    .head_y     (head_y),
    .cubenum    (cubenum),
    .node_cube_x(node_cube_x),
    .node_cube_y(node_cube_y),
    .node       (node),
    .apple_x    (apple_x),
    .apple_y    (apple_y),
    .eat        (eat),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference LFSR, tracks the DUT's register cycle for cycle
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // Body cells sit at x=0 (off-board) unless a collision is being injected
  always_comb begin
    node_cube_x = 6'd0;
    node_cube_y = {2'b00, node};
    if (hit_en && node == hit_node) begin
      node_cube_x = cand_x;
      node_cube_y = cand_y;
    end
  end

  function automatic logic [5:0] cx(input logic [15:0] l);
    int r;
    r = int'(l[5:0]);
    return 6'((r % 38) + 1);
  endfunction

  function automatic logic [5:0] cy(input logic [15:0] l);
    int r;
    r = int'(l[13:8]);
    return 6'((r % 28) + 1);
  endfunction

  // Starts from IDLE at a negedge; walks GEN/SCAN/PLACE with the expected schedule
  task automatic search(input string tag, input int hit_at, input int n_hits, input int n_active);
    int last;
    int scan_len;
    last     = (n_hits > MaxRetry) ? MaxRetry : n_hits;
    hit_node = 4'(hit_at);
    head_x   = apple_x;
    head_y   = apple_y;
    #1;
    total++;
    if (eat !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s start: eat=%b busy=%b want eat=1 busy=0", tag, eat, busy);
    end
    @(negedge clk);
    head_x = 6'd0;
    head_y = 6'd0;
    for (int c = 0; c <= last; c++) begin
      cand_x = cx(m_lfsr);
      cand_y = cy(m_lfsr);
      hit_en = (c < n_hits);
      #1;
      total++;
      if (busy !== 1'b1 || node !== 4'd0 || eat !== 1'b0) begin
        errs++;
        $display("FAIL %s gen%0d: busy=%b node=%0d eat=%b want 1/0/0", tag, c, busy, node, eat);
      end
      scan_len = hit_en ? hit_at + 1 : n_active;
      for (int i = 0; i < scan_len; i++) begin
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || node !== 4'(i)) begin
          errs++;
          $display("FAIL %s scan%0d: busy=%b node=%0d want 1/%0d", tag, c, busy, node, i);
        end
      end
      @(negedge clk);
    end
    hit_en = 1'b0;
    total++;
    if (busy !== 1'b1 || node !== 4'd0) begin
      errs++;
      $display("FAIL %s place: busy=%b node=%0d want 1/0", tag, busy, node);
    end
    @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || eat !== 1'b0 || apple_x !== cand_x || apple_y !== cand_y) begin
      errs++;
      $display("FAIL %s done: busy=%b eat=%b apple=(%0d,%0d) want 0/0/(%0d,%0d)",
               tag, busy, eat, apple_x, apple_y, cand_x, cand_y);
    end
    total++;
    if (apple_x < 6'd1 || apple_x > 6'd38 || apple_y < 6'd1 || apple_y > 6'd28) begin
      errs++;
      $display("FAIL %s range: apple=(%0d,%0d) want x 1..38 y 1..28", tag, apple_x, apple_y);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'd1; head_x = 6'd20; head_y = 6'd15; cubenum = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if (apple_x !== 6'd30 || apple_y !== 6'd10 || eat !== 1'b0 || busy !== 1'b0 || node !== 0) begin
        errs++;
        $display("FAIL reset cyc%0d: apple=(%0d,%0d) eat=%b busy=%b node=%0d want (30,10)/0/0/0",
                 i, apple_x, apple_y, eat, busy, node);
      end
    end
  endtask

  task automatic test_mode_abort();
    head_x = apple_x; head_y = apple_y;
    @(negedge clk);
    head_x = 6'd0; head_y = 6'd0;
    repeat (2) @(negedge clk);
    mode = 2'd0;
    @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || node !== 4'd0 || eat !== 1'b0 || apple_x !== 6'd30 || apple_y !== 6'd10) begin
      errs++;
      $display("FAIL abort: busy=%b node=%0d eat=%b apple=(%0d,%0d) want 0/0/0/(30,10)",
               busy, node, eat, apple_x, apple_y);
    end
    mode = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (eat !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL abort_resume%0d: eat=%b busy=%b want 0/0", i, eat, busy);
      end
    end
  endtask

  task automatic test_mode_other();
    mode = 2'd2;
    head_x = apple_x; head_y = apple_y;
    @(negedge clk);
    #1;
    total++;
    if (apple_x !== 6'd30 || apple_y !== 6'd10 || eat !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL mode2: apple=(%0d,%0d) eat=%b busy=%b want (30,10)/0/0",
               apple_x, apple_y, eat, busy);
    end
    head_x = 6'd0; head_y = 6'd0;
    mode = 2'd1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    head_x = apple_x; head_y = apple_y;
    @(negedge clk);
    head_x = 6'd0; head_y = 6'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || node !== 4'd0 || apple_x !== 6'd30 || apple_y !== 6'd10) begin
      errs++;
      $display("FAIL reset_mid: busy=%b node=%0d apple=(%0d,%0d) want 0/0/(30,10)",
               busy, node, apple_x, apple_y);
    end
  endtask

  task automatic test_random();
    logic [5:0] px, py;
    int k;
    cubenum = 4'd0;
    for (int n = 0; n < 10000; n++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      head_x = apple_x; head_y = apple_y;
      #1;
      total++;
      if (eat !== 1'b1) begin
        errs++;
        $display("FAIL rnd%0d eat: got %b want 1", n, eat);
      end
      @(negedge clk);
      px = cx(m_lfsr); py = cy(m_lfsr);
      head_x = 6'd0; head_y = 6'd0;
      k = 0;
      while (busy === 1'b1 && k < 20) begin
        @(negedge clk);
        k++;
      end
      total++;
      if (busy !== 1'b0 || apple_x !== px || apple_y !== py ||
          apple_x < 6'd1 || apple_x > 6'd38 || apple_y < 6'd1 || apple_y > 6'd28) begin
        errs++;
        $display("FAIL rnd%0d: busy=%b apple=(%0d,%0d) want 0/(%0d,%0d) in range",
                 n, busy, apple_x, apple_y, px, py);
      end
    end
  endtask

  initial begin
    test_reset();
    search("eat_c0", -1, 0, 3);
    cubenum = 4'd2;
    search("retry_node1", 1, 2, 5);
    search("max_retry", 0, MaxRetry + 1, 5);
    cubenum = 4'd14;
    search("full_c14", -1, 0, 16);
    cubenum = 4'd15;
    search("full_c15", -1, 0, 16);
    cubenum = 4'd0;
    test_mode_abort();
    search("eat_after_abort", -1, 0, 3);
    test_mode_other();
    test_reset_mid();
    search("eat_after_rst", -1, 0, 3);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, errs);
    $finish;
  end

endmodule
